serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder controller.
//
// Adds two WIDTH-bit operands plus a carry-in one bit per clock. A single
// 1-bit full adder cell (add1_112) is reused for every bit position.
//
// Optional feature macro: OVERFLOW_FLAG_EN adds the signed-overflow output ovf.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   begin an addition (sampled only in IDLE)
//   a_in      in   [WIDTH-1:0] operand A (captured on the accepting edge)
//   b_in      in   [WIDTH-1:0] operand B (captured on the accepting edge)
//   cin       in   carry-in (captured on the accepting edge)
//   busy      out  high while the addition is in progress (RUN)
//   done      out  one-cycle pulse when sum/cout are freshly valid (DONE)
//   sum       out  [WIDTH-1:0] result of the last completed addition
//   cout      out  carry-out of the last completed addition
//   state_dbg out  [1:0] current FSM state, for checkers
//   ovf       out  signed overflow of the last addition (OVERFLOW_FLAG_EN only)
//
// Handshake: start is a level request with no ready; it is accepted on the
// first rising edge seen in IDLE and ignored in RUN and DONE (no queuing).
// done pulses exactly WIDTH edges after the accepting edge.

module add1_112 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    logic cell_s;
    logic cell_co;

    add1_112 u_cell (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef OVERFLOW_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB, so after WIDTH shifts bit 0
                // of the result has reached the LSB position.
                psum_d  = {cell_s, psum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = cell_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {cell_s, psum_q[WIDTH-1:1]};
                    cout_d  = cell_co;
`ifdef OVERFLOW_FLAG_EN
                    // carry_q is the carry into the MSB, cell_co the carry out.
                    ovf_d   = carry_q ^ cell_co;
`endif
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign state_dbg = state_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): directed cases, start held high,
// reset abort mid-run, and 1000 random additions against an arithmetic
// reference model. Define OVERFLOW_FLAG_EN to also check ovf.

module tb_serial_add_ctrl;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   state_dbg;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .state_dbg (state_dbg)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W+1:0] exp_q[$];      // {ovf, cout, sum}
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer addition; signed overflow when both operands
    // share a sign that the result does not.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         v;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        s    = full[W-1:0];
        v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {v, full[W], s};
    endfunction

    task automatic check_held(input string tag);
        check({tag, "_sum_held"}, sum, held_sum);
        check({tag, "_cout_held"}, cout, held_cout);
`ifdef OVERFLOW_FLAG_EN
        check({tag, "_ovf_held"}, ovf, held_ovf);
`endif
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge with the DUT in IDLE. noise: drive random
    // start/operands while busy; hold: keep start high throughout.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit noise, input bit hold);
        logic [W+1:0] exp;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        exp_q.push_back(ref_add(a, b, c));
        @(posedge clk); #1;
        check("busy_after_accept", busy, 1);
        check("done_after_accept", done, 0);
        for (int j = 1; j <= W + 1; j++) begin
            if (hold)       start = 1'b1;
            else if (noise) start = 1'($urandom_range(0, 1));
            else            start = 1'b0;
            if (noise || hold) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
                cin  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (j < W) begin
                check("busy_run", busy, 1);
                check("done_run", done, 0);
                check_held("run");
            end else if (j == W) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                check("sb_has_entry", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    check("sum", sum, exp[W-1:0]);
                    check("cout", cout, exp[W]);
`ifdef OVERFLOW_FLAG_EN
                    check("ovf", ovf, exp[W+1]);
`endif
                    held_sum  = exp[W-1:0];
                    held_cout = exp[W];
                    held_ovf  = exp[W+1];
                end
            end else begin
                check("done_one_cycle", done, 0);
                check("busy_after_done", busy, 0);
                check_held("post");
            end
        end
        if (!hold) start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin       = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        held_ovf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_held("rst");
        reset = 1'b0;

        // Directed cases
        do_add(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);   // 0x10
        do_add(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);   // 0x00, cout=1, ovf=0
        do_add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);   // 0x01
        do_add(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);   // 0x80, ovf=1
        do_add(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);   // 0x00, cout=1, ovf=1
        do_add(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);   // 0xFF, cout=1

        // start held high: first add unaffected, one done, next accepted in IDLE
        do_add(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        do_add(8'h56, 8'h21, 1'b1, 1'b0, 1'b0);

        // Reset on the 4th RUN edge discards the partial result
        start = 1'b1;
        a_in  = 8'hAA;
        b_in  = 8'h55;
        cin   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_abort", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        held_ovf  = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check_held("abort");
        // Start on the edge right after reset release; no stale done may appear
        do_add(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);   // 0x07

        // Randomised run with noise on inputs while busy
        for (int i = 0; i < 1000; i++) begin
            do_add(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
